// File: rtl/port_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : port_tx_buffer
// Purpose  : Per-ingress-port packet buffer and transmitter. Words from an
//            external source are stored, committed a whole packet at a time,
//            and replayed one word per next_data pulse toward the write
//            arbiter with sop/eop/vld framing.
// Ports    : clk, rst       - clock (rising edge), async active-high reset
//            in_vld/in_sop/in_eop/in_data - input word and framing
//            in_ready       - buffer can take a word this cycle
//            next_data      - arbiter pop request, one word per cycle
//            ready          - at least one complete packet stored
//            vld/sop/eop/data_out - head word (first-word-fall-through)
//            pkt_count      - complete packets stored
//            drop_cnt       - words discarded by protocol errors (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module port_tx_buffer #(
    parameter int ARBITER_DATA_WIDTH = 64,
    parameter int FIFO_DEPTH         = 64,
    parameter int CNT_WIDTH          = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_vld,
    input  logic                          in_sop,
    input  logic                          in_eop,
    input  logic [ARBITER_DATA_WIDTH-1:0] in_data,
    output logic                          in_ready,
    input  logic                          next_data,
    output logic                          ready,
    output logic                          vld,
    output logic                          sop,
    output logic                          eop,
    output logic [ARBITER_DATA_WIDTH-1:0] data_out,
    output logic [CNT_WIDTH-1:0]          pkt_count,
    output logic [CNT_WIDTH-1:0]          drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int MW = ARBITER_DATA_WIDTH + 2;
    // Sum width wide enough for drop_cnt plus a whole discarded packet.
    localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;

    localparam logic [0:0]           c_rx_idle = 1'b0;
    localparam logic [0:0]           c_rx_recv = 1'b1;
    localparam logic [PW-1:0]        c_depth   = PW'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    // Storage word layout: {sop, eop, data}
    logic [MW-1:0] r_mem [FIFO_DEPTH];

    logic [0:0]           r_rx_state_q,   w_rx_state_d;
    logic [PW-1:0]        r_wr_ptr_q,     w_wr_ptr_d;
    logic [PW-1:0]        r_commit_ptr_q, w_commit_ptr_d;
    logic [PW-1:0]        r_rd_ptr_q,     w_rd_ptr_d;
    logic [PW-1:0]        r_pkt_start_q,  w_pkt_start_d;
    logic [CNT_WIDTH-1:0] r_pkt_count_q,  w_pkt_count_d;
    logic [CNT_WIDTH-1:0] r_drop_cnt_q,   w_drop_cnt_d;

    logic          w_full;
    logic          w_accept;
    logic          w_vld;
    logic [MW-1:0] w_head;
    logic          w_pop;
    logic          w_pop_eop;
    logic          w_commit;
    logic [PW-1:0] w_base;
    logic [SW-1:0] w_drop_add;
    logic [SW-1:0] w_drop_sum;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [MW-1:0] w_mem_wdata;

    // Full/empty decode uses registered pointers only, so in_ready has no
    // combinational path from the pop request.
    assign w_full    = (r_wr_ptr_q - r_rd_ptr_q) == c_depth;
    assign w_accept  = in_vld & ~w_full;
    assign w_vld     = r_rd_ptr_q != r_commit_ptr_q;
    assign w_head    = r_mem[r_rd_ptr_q[AW-1:0]];
    assign w_pop     = next_data & w_vld;
    assign w_pop_eop = w_pop & w_head[ARBITER_DATA_WIDTH];

    // Receive FSM: next state, write port and pointer updates.
    always_comb begin
        w_rx_state_d   = r_rx_state_q;
        w_wr_ptr_d     = r_wr_ptr_q;
        w_commit_ptr_d = r_commit_ptr_q;
        w_pkt_start_d  = r_pkt_start_q;
        w_commit       = 1'b0;
        w_base         = r_wr_ptr_q;
        w_drop_add     = '0;
        w_mem_we       = 1'b0;
        w_mem_addr     = r_wr_ptr_q[AW-1:0];
        w_mem_wdata    = {in_sop, in_eop, in_data};
        case (r_rx_state_q)
            c_rx_idle: begin
                if (w_accept) begin
                    if (in_sop) begin
                        w_mem_we      = 1'b1;
                        w_pkt_start_d = r_wr_ptr_q;
                        w_wr_ptr_d    = r_wr_ptr_q + 1'b1;
                        if (in_eop) begin
                            w_commit       = 1'b1;
                            w_commit_ptr_d = r_wr_ptr_q + 1'b1;
                        end else begin
                            w_rx_state_d = c_rx_recv;
                        end
                    end else begin
                        // Word outside any packet: discard it.
                        w_drop_add = SW'(1);
                    end
                end
            end
            c_rx_recv: begin
                if (w_accept) begin
                    // A new header mid-packet abandons the partial packet and
                    // restarts writing at its first slot.
                    if (in_sop) begin
                        w_base     = r_pkt_start_q;
                        w_drop_add = SW'(r_wr_ptr_q - r_pkt_start_q);
                    end
                    w_mem_we   = 1'b1;
                    w_mem_addr = w_base[AW-1:0];
                    w_wr_ptr_d = w_base + 1'b1;
                    if (in_eop) begin
                        w_commit       = 1'b1;
                        w_commit_ptr_d = w_base + 1'b1;
                        w_rx_state_d   = c_rx_idle;
                    end
                end
            end
            default: w_rx_state_d = c_rx_idle;
        endcase
    end

    // Saturating drop counter, packet counter and read pointer.
    always_comb begin
        w_drop_sum   = SW'(r_drop_cnt_q) + w_drop_add;
        w_drop_cnt_d = (w_drop_sum > SW'(c_cnt_max)) ? c_cnt_max
                                                      : w_drop_sum[CNT_WIDTH-1:0];
        w_pkt_count_d = r_pkt_count_q;
        case ({w_commit, w_pop_eop})
            2'b10:   w_pkt_count_d = r_pkt_count_q + 1'b1;
            2'b01:   w_pkt_count_d = r_pkt_count_q - 1'b1;
            default: w_pkt_count_d = r_pkt_count_q;
        endcase
        w_rd_ptr_d = w_pop ? (r_rd_ptr_q + 1'b1) : r_rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state_q   <= c_rx_idle;
            r_wr_ptr_q     <= '0;
            r_commit_ptr_q <= '0;
            r_rd_ptr_q     <= '0;
            r_pkt_start_q  <= '0;
            r_pkt_count_q  <= '0;
            r_drop_cnt_q   <= '0;
        end else begin
            r_rx_state_q   <= w_rx_state_d;
            r_wr_ptr_q     <= w_wr_ptr_d;
            r_commit_ptr_q <= w_commit_ptr_d;
            r_rd_ptr_q     <= w_rd_ptr_d;
            r_pkt_start_q  <= w_pkt_start_d;
            r_pkt_count_q  <= w_pkt_count_d;
            r_drop_cnt_q   <= w_drop_cnt_d;
        end
    end

    // Storage needs no reset: a slot is only visible once committed.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign in_ready  = ~w_full;
    assign ready     = r_pkt_count_q != '0;
    assign vld       = w_vld;
    assign sop       = w_vld & w_head[ARBITER_DATA_WIDTH+1];
    assign eop       = w_vld & w_head[ARBITER_DATA_WIDTH];
    assign data_out  = w_vld ? w_head[ARBITER_DATA_WIDTH-1:0] : '0;
    assign pkt_count = r_pkt_count_q;
    assign drop_cnt  = r_drop_cnt_q;

endmodule
`default_nettype wire
